// File: rtl/dot2_pkg.sv
// Shared constants, ID-width helper and pipeline sideband type for the dot2 arbiter slice.
package dot2_pkg;

  localparam int DW_DEFAULT = 32;
  // Sideband ID is sized for the largest legal requester count (16).
  localparam int MAX_IDW = 4;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic               valid;
    logic [MAX_IDW-1:0] id;
  } sb_t;

endpackage

// File: rtl/dot2_pipe.sv
// Two-stage multiply-add datapath (A1*B1 + A2*B2) carrying a valid/ID sideband.
// Result and ID hold their last values between valid strobes.
module dot2_pipe
  import dot2_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid_i,
  input  logic [MAX_IDW-1:0] in_id_i,
  input  logic [DW-1:0]      a1_i,
  input  logic [DW-1:0]      b1_i,
  input  logic [DW-1:0]      a2_i,
  input  logic [DW-1:0]      b2_i,
  output logic               out_valid_o,
  output logic [MAX_IDW-1:0] out_id_o,
  output logic [DW-1:0]      out_data_o,
  output logic               busy_o
);

  sb_t           sb1_q, sb1_d;
  sb_t           sb2_q, sb2_d;
  logic [DW-1:0] p1_q, p2_q;
  logic [DW-1:0] sum_q, sum_d;

  // Products never reach the output unless their stage-1 valid is set.
  always_ff @(posedge clk) begin
    if (in_valid_i) begin
      p1_q <= a1_i * b1_i;
      p2_q <= a2_i * b2_i;
    end
  end

  always_comb begin
    sb1_d.valid = in_valid_i;
    sb1_d.id    = in_valid_i ? in_id_i : sb1_q.id;
    sb2_d.valid = sb1_q.valid;
    sb2_d.id    = sb1_q.valid ? sb1_q.id : sb2_q.id;
    sum_d       = sb1_q.valid ? (p1_q + p2_q) : sum_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb1_q <= '0;
      sb2_q <= '0;
      sum_q <= '0;
    end else begin
      sb1_q <= sb1_d;
      sb2_q <= sb2_d;
      sum_q <= sum_d;
    end
  end

  assign out_valid_o = sb2_q.valid;
  assign out_id_o    = sb2_q.id;
  assign out_data_o  = sum_q;
  assign busy_o      = sb1_q.valid | sb2_q.valid;

endmodule

// File: rtl/dot2_arbiter.sv
// Round-robin arbiter sharing one dot2_pipe between NUM_REQ requesters.
// Define DOT2_ARBITER_LOCK_EN to add the lock input that pins the pointer on a winner.
module dot2_arbiter
  import dot2_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DW      = DW_DEFAULT,
  parameter int IDW     = id_width(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef DOT2_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0]    lock,
`endif
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DW-1:0] a1,
  input  logic [NUM_REQ*DW-1:0] a2,
  input  logic [NUM_REQ*DW-1:0] b1,
  input  logic [NUM_REQ*DW-1:0] b2,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic [DW-1:0]         res_data,
  output logic                  busy
);

  logic [DW-1:0]      a1_arr [NUM_REQ];
  logic [DW-1:0]      a2_arr [NUM_REQ];
  logic [DW-1:0]      b1_arr [NUM_REQ];
  logic [DW-1:0]      b2_arr [NUM_REQ];
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     win;
  logic [IDW:0]       idx;
  logic               found;
  logic               accept;
  logic [MAX_IDW-1:0] out_id;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a1_arr[gi] = a1[gi*DW +: DW];
      assign a2_arr[gi] = a2[gi*DW +: DW];
      assign b1_arr[gi] = b1[gi*DW +: DW];
      assign b2_arr[gi] = b2[gi*DW +: DW];
    end
  endgenerate

  // Walk the requesters in priority order starting at the pointer.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NUM_REQ)) begin
        idx = idx - (IDW+1)'(NUM_REQ);
      end
      if (!found && req[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  assign accept = found & ~reset;
  assign gnt    = accept ? (NUM_REQ'(1) << win) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`ifdef DOT2_ARBITER_LOCK_EN
      if (lock[win]) begin
        ptr_d = win;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  dot2_pipe #(
    .DW(DW)
  ) u_pipe (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (accept),
    .in_id_i    (MAX_IDW'(win)),
    .a1_i       (a1_arr[win]),
    .b1_i       (b1_arr[win]),
    .a2_i       (a2_arr[win]),
    .b2_i       (b2_arr[win]),
    .out_valid_o(res_valid),
    .out_id_o   (out_id),
    .out_data_o (res_data),
    .busy_o     (busy)
  );

  assign res_id = out_id[IDW-1:0];

endmodule
